fft_addr_gen: RTL and testbench

FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

---
 rtl/fft_addr_gen_if.sv | 29 ++
 rtl/fft_addr_gen.sv | 162 ++++++++++++++++
 tb/tb_fft_addr_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fft_addr_gen_if.sv
// rtl/fft_addr_gen_if.sv - start/status and memory address bus of the FFT address generator
interface fft_addr_gen_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addra;
  logic [ADDR_WIDTH-1:0] rd_addrb;
  logic [ADDR_WIDTH-2:0] twiddle_addr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addra;
  logic [ADDR_WIDTH-1:0] wr_addrb;
  logic                  scale;
  logic [3:0]            stage;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addra, rd_addrb, twiddle_addr,
    output wr_en, wr_addra, wr_addrb, scale, stage
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addra, rd_addrb, twiddle_addr,
    input  wr_en, wr_addra, wr_addrb, scale, stage
  );
endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - radix-2 DIT in-place stage sequencer with delayed write-back addressing
module fft_addr_gen #(
  parameter int FFT_SIZE     = 4096,
  parameter int ADDR_WIDTH   = 12,
  parameter int RD_LATENCY   = 1,
  parameter int BFLY_LATENCY = 5
) (
  input  logic          clk,
  input  logic          rst,
  fft_addr_gen_if.master bus
);
  localparam int              L          = RD_LATENCY + BFLY_LATENCY;
  localparam int              JW         = ADDR_WIDTH - 1;
  localparam logic [JW-1:0]   J_LAST     = JW'(FFT_SIZE / 2 - 1);
  localparam logic [7:0]      D_LAST     = 8'(L - 1);
  localparam logic [3:0]      LAST_STAGE = 4'(ADDR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [JW-1:0]         j;
  logic [JW-1:0]         j_nxt;
  logic [3:0]            stage;
  logic [3:0]            stage_nxt;
  logic [7:0]            dcnt;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [JW-1:0]         tw_q;

  logic [L-1:0]          pv;
  logic [L-1:0]          ps;
  logic [ADDR_WIDTH-1:0] pa [L];
  logic [ADDR_WIDTH-1:0] pb [L];

  assign j_nxt     = j + 1'b1;
  assign stage_nxt = stage + 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] addr_a(input logic [3:0] st, input logic [JW-1:0] jj);
    logic [ADDR_WIDTH-1:0] jx;
    logic [ADDR_WIDTH-1:0] mask;
    jx   = ADDR_WIDTH'(jj);
    mask = (ADDR_WIDTH'(1) << st) - ADDR_WIDTH'(1);
    return ((jx >> st) << (st + 4'd1)) | (jx & mask);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_b(input logic [3:0] st, input logic [JW-1:0] jj);
    return addr_a(st, jj) + (ADDR_WIDTH'(1) << st);
  endfunction

  // Twiddle index k * N/(2*span): the in-group offset scaled to the full ROM.
  function automatic logic [JW-1:0] tw_of(input logic [3:0] st, input logic [JW-1:0] jj);
    logic [JW-1:0] mask;
    mask = (JW'(1) << st) - JW'(1);
    return (jj & mask) << (4'(JW) - st);
  endfunction

  // Addresses are registered one step ahead so they line up with rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      j       <= '0;
      stage   <= '0;
      dcnt    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addra_q <= '0;
      addrb_q <= '0;
      tw_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            stage   <= '0;
            j       <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addra_q <= addr_a(4'd0, JW'(0));
            addrb_q <= addr_b(4'd0, JW'(0));
            tw_q    <= tw_of(4'd0, JW'(0));
          end
        end
        RUN: begin
          if (j == J_LAST) begin
            state   <= DRAIN;
            j       <= '0;
            dcnt    <= '0;
            rd_en_q <= 1'b0;
          end else begin
            j       <= j_nxt;
            addra_q <= addr_a(stage, j_nxt);
            addrb_q <= addr_b(stage, j_nxt);
            tw_q    <= tw_of(stage, j_nxt);
          end
        end
        DRAIN: begin
          // Waiting out the full read+butterfly latency keeps the next stage from reading stale data.
          if (dcnt == D_LAST) begin
            if (stage == LAST_STAGE) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state   <= RUN;
              stage   <= stage_nxt;
              rd_en_q <= 1'b1;
              addra_q <= addr_a(stage_nxt, JW'(0));
              addrb_q <= addr_b(stage_nxt, JW'(0));
              tw_q    <= tw_of(stage_nxt, JW'(0));
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      ps <= '0;
      for (int k = 0; k < L; k++) begin
        pa[k] <= '0;
        pb[k] <= '0;
      end
    end else begin
      pv[0] <= rd_en_q;
      ps[0] <= stage[0];
      pa[0] <= addra_q;
      pb[0] <= addrb_q;
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];
        ps[k] <= ps[k-1];
        pa[k] <= pa[k-1];
        pb[k] <= pb[k-1];
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addra     = addra_q;
  assign bus.rd_addrb     = addrb_q;
  assign bus.twiddle_addr = tw_q;
  assign bus.stage        = stage;
  assign bus.wr_en        = pv[L-1];
  assign bus.wr_addra     = pa[L-1];
  assign bus.wr_addrb     = pb[L-1];
  // Odd stages halve the butterfly output: 1/sqrt(N) overall for even ADDR_WIDTH.
  assign bus.scale        = ps[L-1] & pv[L-1];
endmodule

// File: tb/tb_fft_addr_gen.sv
// tb/tb_fft_addr_gen.sv - scoreboard bench for fft_addr_gen with an impulse-FFT data model
module tb_fft_addr_gen;
  localparam int N      = 16;
  localparam int AW     = 4;
  localparam int RDL    = 1;
  localparam int BFL    = 5;
  localparam int L      = RDL + BFL;
  localparam int HALF   = N / 2;
  localparam int RUNLEN = 1 + AW * (HALF + L);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_addr_gen_if #(.ADDR_WIDTH(AW)) bus ();

  fft_addr_gen #(
    .FFT_SIZE(N), .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .BFLY_LATENCY(BFL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int bcnt = 0;

  logic [63:0] rdq[$];
  logic [63:0] wrq[$];
  int          doneq[$];
  real         qar[$], qai[$], qbr[$], qbi[$];
  int          qtw[$];
  real         mre[N];
  real         mim[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got an output event, required none", nm);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.scale, bus.rd_addra, bus.rd_addrb,
                bus.twiddle_addr, bus.wr_addra, bus.wr_addrb, bus.stage});
  endfunction

  task automatic flush();
    rdq.delete(); wrq.delete(); doneq.delete();
    qar.delete(); qai.delete(); qbr.delete(); qbi.delete(); qtw.delete();
    bcnt = 0;
  endtask

  // Monitor: pops the scoreboard on every DUT event and runs the butterfly data model.
  real ar, ai, br, bi, wre, wim, tr, ti, f, ang;
  always @(negedge clk) begin : mon
    logic [63:0] got;
    int          wa, wb;
    if (!rst) begin
      if (bus.busy) bcnt++;
      if (bus.rd_en) begin
        got = {32'(cyc), 8'(bus.stage), 8'(bus.rd_addra), 8'(bus.rd_addrb), 8'(bus.twiddle_addr)};
        if (rdq.size() == 0) flag("unexpected_rd");
        else chk("rd", got, rdq.pop_front());
        qar.push_back(mre[bus.rd_addra]); qai.push_back(mim[bus.rd_addra]);
        qbr.push_back(mre[bus.rd_addrb]); qbi.push_back(mim[bus.rd_addrb]);
        qtw.push_back(int'(bus.twiddle_addr));
      end
      if (bus.wr_en) begin
        got = {32'(cyc), 8'(bus.wr_addra), 8'(bus.wr_addrb), 8'(bus.scale), 8'h00};
        if (wrq.size() == 0) flag("unexpected_wr");
        else chk("wr", got, wrq.pop_front());
        if (qar.size() > 0) begin
          ar = qar.pop_front(); ai = qai.pop_front();
          br = qbr.pop_front(); bi = qbi.pop_front();
          ang = 2.0 * 3.14159265358979 * real'(qtw.pop_front()) / real'(N);
          wre = $cos(ang); wim = -$sin(ang);
          tr = br * wre - bi * wim;
          ti = br * wim + bi * wre;
          f = bus.scale ? 0.5 : 1.0;
          wa = int'(bus.wr_addra); wb = int'(bus.wr_addrb);
          mre[wa] = (ar + tr) * f; mim[wa] = (ai + ti) * f;
          mre[wb] = (ar - tr) * f; mim[wb] = (ai - ti) * f;
        end
      end else if (bus.scale) begin
        flag("scale_without_wr");
      end
      if (bus.done) begin
        if (doneq.size() == 0) flag("unexpected_done");
        else chk("done_cycle", 64'(cyc), 64'(doneq.pop_front()));
        chk("busy_cycles", 64'(bcnt), 64'(RUNLEN - 1));
        chk("busy_at_done", 64'(bus.busy), 64'(0));
        bcnt = 0;
        done_cnt++;
      end
    end
  end

  // One transform; abort_at > 0 asserts rst that many cycles after the start pulse.
  task automatic run_fft(input int abort_at);
    int c, d0, gap, nw, span, g, k, a, rc;
    gap = $urandom_range(0, 4);
    repeat (gap) begin @(posedge clk); #1; end
    for (int i = 0; i < N; i++) begin mre[i] = 0.0; mim[i] = 0.0; end
    mre[0] = 64.0;
    c  = cyc;
    d0 = done_cnt;
    for (int s = 0; s < AW; s++) begin
      span = 1 << s;
      for (int jj = 0; jj < HALF; jj++) begin
        g  = jj / span;
        k  = jj % span;
        a  = 2 * span * g + k;
        rc = c + 1 + s * (HALF + L) + jj;
        rdq.push_back({32'(rc), 8'(s), 8'(a), 8'(a + span), 8'(k * HALF / span)});
        wrq.push_back({32'(rc + L), 8'(a), 8'(a + span), 8'(s % 2), 8'h00});
      end
    end
    doneq.push_back(c + RUNLEN);
    bus.start = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (abort_at > 0 && cyc == c + abort_at) begin
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_outputs", all_outs(), 64'(0));
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        nw = 0;
        repeat (10) begin @(negedge clk); if (bus.wr_en) nw++; end
        chk("wr_after_abort", 64'(nw), 64'(0));
        @(posedge clk); #1;
        return;
      end
      if (done_cnt != d0) begin
        bus.start = 1'b0;
        break;
      end
      if (cyc - c > 3 * RUNLEN) begin
        bus.start = 1'b0;
        tests++; fails++;
        $display("FAIL done_timeout: got no done after %0d cycles, required %0d", cyc - c, RUNLEN);
        flush();
        return;
      end
      // Extra starts while busy must be ignored.
      bus.start = (cyc - c <= RUNLEN) && ($urandom_range(0, 3) == 0);
    end
    chk("queues_drained", 64'(rdq.size() + wrq.size()), 64'(0));
    for (int b = 0; b < N; b++) begin
      chk($sformatf("bin_re[%0d]x1000", b), 64'($rtoi(mre[b] * 1000.0 + 0.5)), 64'(16000));
      chk($sformatf("bin_im[%0d]x1000", b), 64'($rtoi(mim[b] * 1000.0 + 0.5)), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", all_outs(), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    run_fft(0);
    run_fft(29 + $urandom_range(0, 7));
    run_fft(0);
    run_fft(1 + $urandom_range(0, 55));
    repeat (3) run_fft(0);
    chk("final_queues", 64'(rdq.size() + wrq.size() + doneq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
